// File: rtl/cluster_frame_builder.sv
// Buffers per-bx cluster sets in a small FIFO and streams each bx out as one or two
// 4-cluster frames over a valid/ready handshake, tagged with the bx number.

module cluster_valid_chk #(
  parameter int MXCLSTBITS = 14
) (
  input  logic [MXCLSTBITS-1:0] cluster,
  output logic                  valid
);
  // 0x7FF is the packer's empty marker; nothing at or above 1536 is a real address
  assign valid = (cluster[10:0] < 11'd1536);
endmodule

module cluster_frame_builder #(
  parameter int MXCLSTBITS = 14,
  parameter int MXCLUSTERS = 8,
  parameter int MXOUTBITS  = 56,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock4x,
  input  logic                  global_reset_n,
  input  logic                  bx_strobe,
  input  logic                  bc0,
  input  logic [MXCLSTBITS-1:0] cluster0,
  input  logic [MXCLSTBITS-1:0] cluster1,
  input  logic [MXCLSTBITS-1:0] cluster2,
  input  logic [MXCLSTBITS-1:0] cluster3,
  input  logic [MXCLSTBITS-1:0] cluster4,
  input  logic [MXCLSTBITS-1:0] cluster5,
  input  logic [MXCLSTBITS-1:0] cluster6,
  input  logic [MXCLSTBITS-1:0] cluster7,
  output logic [MXOUTBITS-1:0]  frame,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_last,
  output logic [11:0]           frame_bxn,
  output logic                  fifo_full,
  output logic [15:0]           overflow_cnt
);

  localparam int HALF = MXCLUSTERS / 2;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [11:0] BX_MAX = 12'd3563;

  typedef struct packed {
    logic [MXCLUSTERS-1:0]                 vmask;
    logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0] clus;
    logic [11:0]                           bxn;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0] clus_in;
  logic [MXCLUSTERS-1:0]                 vmask_in;

  assign clus_in = {cluster7, cluster6, cluster5, cluster4,
                    cluster3, cluster2, cluster1, cluster0};

  for (genvar g = 0; g < MXCLUSTERS; g++) begin : g_vchk
    cluster_valid_chk #(.MXCLSTBITS(MXCLSTBITS)) u_vchk (
      .cluster (clus_in[g]),
      .valid   (vmask_in[g])
    );
  end

  // bx counter and one-cycle capture stage ahead of the FIFO write
  logic [11:0] bxn, cap_bxn;
  logic        wr_req;
  entry_t      wr_entry;

  assign cap_bxn = bc0 ? 12'd0 : bxn;

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      bxn      <= '0;
      wr_req   <= 1'b0;
      wr_entry <= '0;
    end else begin
      wr_req <= bx_strobe && (|vmask_in);
      if (bx_strobe) begin
        bxn      <= bc0 ? 12'd1 : ((bxn == BX_MAX) ? 12'd0 : bxn + 12'd1);
        wr_entry <= '{vmask: vmask_in, clus: clus_in, bxn: cap_bxn};
      end
    end
  end

  // FIFO; the head entry stays stored until its last frame is accepted
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_nxt  = ptr_inc(rd_ptr);
  assign push    = wr_req && (!fifo_full || pop);
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clock4x) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      fifo_full    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_nxt;
      cnt       <= cnt_nxt;
      fifo_full <= (cnt_nxt == CW'(FIFO_DEPTH));
      if (wr_req && !push && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // output FSM
  state_t state, state_n;
  entry_t out_e;
  logic   load, load_nxt, hs, lo_last;

  assign lo_last = ~|out_e.vmask[MXCLUSTERS-1:HALF];
  assign hs      = frame_valid && frame_ready;

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state <= IDLE;
      out_e <= '0;
    end else begin
      state <= state_n;
      if (load) out_e <= load_nxt ? mem[rd_nxt] : mem[rd_ptr];
    end
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_nxt = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (cnt != '0) begin
          load    = 1'b1;
          state_n = SEND_LO;
        end
      end
      SEND_LO, SEND_HI: begin
        if (hs) begin
          if (state == SEND_LO && !lo_last) begin
            state_n = SEND_HI;
          end else begin
            pop = 1'b1;
            // the entry behind the popped head is only visible if already stored
            if (cnt > CW'(1)) begin
              load     = 1'b1;
              load_nxt = 1'b1;
              state_n  = SEND_LO;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign frame_valid = (state != IDLE);

  always_comb begin
    frame      = '0;
    frame_last = 1'b0;
    frame_bxn  = '0;
    case (state)
      SEND_LO: begin
        frame      = out_e.clus[HALF-1:0];
        frame_last = lo_last;
        frame_bxn  = out_e.bxn;
      end
      SEND_HI: begin
        frame      = out_e.clus[MXCLUSTERS-1:HALF];
        frame_last = 1'b1;
        frame_bxn  = out_e.bxn;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cluster_frame_builder.sv
// Directed bench for cluster_frame_builder: latency, hold under backpressure,
// FIFO full/overflow, bx wrap, reset mid-frame.

module tb_cluster_frame_builder;

  localparam logic [13:0] INV = 14'h07FF;

  logic        clock4x = 1'b0;
  logic        global_reset_n;
  logic        bx_strobe = 1'b0;
  logic        bc0 = 1'b0;
  logic        frame_ready = 1'b0;
  logic [13:0] cl [8];
  logic [55:0] frame;
  logic        frame_valid, frame_last, fifo_full;
  logic [11:0] frame_bxn;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clock4x = ~clock4x;

  cluster_frame_builder dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .bx_strobe      (bx_strobe),
    .bc0            (bc0),
    .cluster0       (cl[0]),
    .cluster1       (cl[1]),
    .cluster2       (cl[2]),
    .cluster3       (cl[3]),
    .cluster4       (cl[4]),
    .cluster5       (cl[5]),
    .cluster6       (cl[6]),
    .cluster7       (cl[7]),
    .frame          (frame),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_last     (frame_last),
    .frame_bxn      (frame_bxn),
    .fifo_full      (fifo_full),
    .overflow_cnt   (overflow_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] fr(input logic [13:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic set_all(input logic [13:0] v);
    for (int i = 0; i < 8; i++) cl[i] = v;
  endtask

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic strobe_once();
    bx_strobe = 1'b1;
    tick();
    bx_strobe = 1'b0;
    bc0 = 1'b0;
    set_all(INV);
  endtask

  // waits (bounded) for a frame with ready held high, checks it, lets it handshake
  task automatic take(input string tag, input logic [55:0] f, input logic l,
                      input logic [11:0] b, output int waited);
    frame_ready = 1'b1;
    waited = 0;
    @(negedge clock4x);
    while (!frame_valid && waited < 20) begin
      waited++;
      @(negedge clock4x);
    end
    chk({tag, ".valid"}, 64'(frame_valid), 64'd1);
    chk({tag, ".frame"}, 64'(frame), 64'(f));
    chk({tag, ".last"},  64'(frame_last), 64'(l));
    chk({tag, ".bxn"},   64'(frame_bxn), 64'(b));
    tick();
  endtask

  initial begin
    int w;
    int seen;
    set_all(INV);
    global_reset_n = 1'b1;
    #1 global_reset_n = 1'b0;
    repeat (2) tick();
    chk("rst.frame", 64'(frame), 64'd0);
    chk("rst.valid", 64'(frame_valid), 64'd0);
    chk("rst.last",  64'(frame_last), 64'd0);
    chk("rst.bxn",   64'(frame_bxn), 64'd0);
    chk("rst.full",  64'(fifo_full), 64'd0);
    chk("rst.ovf",   64'(overflow_cnt), 64'd0);
    @(negedge clock4x);
    global_reset_n = 1'b1;
    tick();

    // single-frame bx with bc0, latency of two edges
    frame_ready = 1'b1;
    bc0 = 1'b1;
    cl[0] = 14'h0805;
    strobe_once();
    @(negedge clock4x);
    chk("lat.n0", 64'(frame_valid), 64'd0);
    @(negedge clock4x);
    chk("lat.n1", 64'(frame_valid), 64'd0);
    @(negedge clock4x);
    chk("lat.n2", 64'(frame_valid), 64'd1);
    chk("lat.frame", 64'(frame), 64'(fr(14'h0805, INV, INV, INV)));
    chk("lat.last", 64'(frame_last), 64'd1);
    chk("lat.bxn", 64'(frame_bxn), 64'd0);
    @(negedge clock4x);
    chk("lat.done", 64'(frame_valid), 64'd0);

    // two-frame bx held under backpressure
    frame_ready = 1'b0;
    cl[5] = 14'h1234;
    strobe_once();
    repeat (2) @(negedge clock4x);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock4x);
      chk("hold.valid", 64'(frame_valid), 64'd1);
      chk("hold.frame", 64'(frame), 64'(fr(INV, INV, INV, INV)));
      chk("hold.last",  64'(frame_last), 64'd0);
      chk("hold.bxn",   64'(frame_bxn), 64'd1);
      if (i == 3) frame_ready = 1'b1;
    end
    @(negedge clock4x);
    chk("hi.valid", 64'(frame_valid), 64'd1);
    chk("hi.frame", 64'(frame), 64'(fr(INV, 14'h1234, INV, INV)));
    chk("hi.last",  64'(frame_last), 64'd1);
    chk("hi.bxn",   64'(frame_bxn), 64'd1);
    tick();
    frame_ready = 1'b0;

    // bc0 without strobe is ignored; then overflow with six strobes
    bc0 = 1'b1;
    tick();
    bc0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cl[0] = 14'h0010 + 14'(i);
      bx_strobe = 1'b1;
      tick();
      if (i == 3) chk("ovf.notfull", 64'(fifo_full), 64'd0);
    end
    bx_strobe = 1'b0;
    set_all(INV);
    repeat (2) tick();
    chk("ovf.full", 64'(fifo_full), 64'd1);
    chk("ovf.cnt",  64'(overflow_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      take("ovf.drain", fr(14'h0010 + 14'(i), INV, INV, INV), 1'b1, 12'd2 + 12'(i), w);
      if (i > 0) chk("ovf.b2b", 64'(w), 64'd0);
    end
    chk("ovf.emptied", 64'(fifo_full), 64'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clock4x);
      if (frame_valid) seen++;
    end
    chk("ovf.nomore", 64'(seen), 64'd0);

    // 3564 invalid strobes (adr 1536) from bc0: no frames, counter wraps to 0
    seen = 0;
    for (int i = 0; i < 3564; i++) begin
      set_all(14'h0600);
      bc0 = (i == 0);
      bx_strobe = 1'b1;
      tick();
      if (frame_valid) seen++;
    end
    bx_strobe = 1'b0;
    bc0 = 1'b0;
    repeat (3) begin
      tick();
      if (frame_valid) seen++;
    end
    chk("wrap.noframes", 64'(seen), 64'd0);
    set_all(INV);
    cl[1] = 14'h0600;
    cl[2] = 14'h05FF;
    cl[3] = 14'h3FFF;
    strobe_once();
    take("wrap", fr(INV, 14'h0600, 14'h05FF, 14'h3FFF), 1'b1, 12'd0, w);

    // full FIFO: write coincident with a popping handshake is accepted
    frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cl[0] = 14'h0020 + 14'(i);
      bx_strobe = 1'b1;
      tick();
    end
    bx_strobe = 1'b0;
    set_all(INV);
    repeat (2) tick();
    chk("pw.full", 64'(fifo_full), 64'd1);
    chk("pw.ovf0", 64'(overflow_cnt), 64'd2);
    cl[0] = 14'h0024;
    strobe_once();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("pw.full2", 64'(fifo_full), 64'd1);
    chk("pw.ovf1",  64'(overflow_cnt), 64'd2);
    for (int i = 0; i < 4; i++)
      take("pw.drain", fr(14'h0021 + 14'(i), INV, INV, INV), 1'b1, 12'd2 + 12'(i), w);
    frame_ready = 1'b0;

    // reset during SEND_HI with two entries stored
    cl[4] = 14'h0100;
    bx_strobe = 1'b1;
    tick();
    set_all(INV);
    cl[0] = 14'h0001;
    strobe_once();
    take("rs.lo", fr(INV, INV, INV, INV), 1'b0, 12'd6, w);
    frame_ready = 1'b0;
    @(negedge clock4x);
    chk("rs.hi.valid", 64'(frame_valid), 64'd1);
    chk("rs.hi.frame", 64'(frame), 64'(fr(14'h0100, INV, INV, INV)));
    global_reset_n = 1'b0;
    #1;
    chk("rs.frame", 64'(frame), 64'd0);
    chk("rs.valid", 64'(frame_valid), 64'd0);
    chk("rs.last",  64'(frame_last), 64'd0);
    chk("rs.bxn",   64'(frame_bxn), 64'd0);
    chk("rs.full",  64'(fifo_full), 64'd0);
    chk("rs.ovf",   64'(overflow_cnt), 64'd0);
    set_all(14'h0000);
    bx_strobe = 1'b1;
    repeat (2) tick();
    bx_strobe = 1'b0;
    set_all(INV);
    @(negedge clock4x);
    global_reset_n = 1'b1;
    frame_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock4x);
      if (frame_valid) seen++;
    end
    chk("rs.noframes", 64'(seen), 64'd0);
    tick();
    cl[0] = 14'h0333;
    strobe_once();
    take("rs.new", fr(14'h0333, INV, INV, INV), 1'b1, 12'd0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
